// File: rtl/param_mem_pkg.sv
// Shared types and constants for the parametrised request/response memory.
package param_mem_pkg;

  typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {OP_RD, OP_WR, OP_ERR} op_t;

  localparam int WAIT_W = 4;

  function automatic op_t decode_op(input logic w_en, input logic r_en, input logic in_range);
    if (!in_range || (w_en == r_en)) return OP_ERR;
    return w_en ? OP_WR : OP_RD;
  endfunction

endpackage

// File: rtl/param_mem_array.sv
// Storage array: one byte-enabled synchronous write port, one synchronous read port.
module param_mem_array #(
  parameter  int DATA_W = 8,
  parameter  int ADDR_W = 7,
  parameter  int DEPTH  = 2**ADDR_W,
  localparam int BE_W   = DATA_W/8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [BE_W-1:0]   wbe,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/param_mem.sv
// Single-port memory with ready/valid requests, wait states, error pulses and a post-reset clear sweep.
import param_mem_pkg::*;

module param_mem #(
  parameter  int DATA_W   = 8,
  parameter  int ADDR_W   = 7,
  parameter  int DEPTH    = 2**ADDR_W,
  parameter  int WAIT_CYC = 0,
  localparam int BE_W     = DATA_W/8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              w_en,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              err
);

  state_t              state;
  op_t                 op;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [BE_W-1:0]     req_be;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [ADDR_W-1:0]   clear_cnt;
  logic                access;
  logic                in_range;

  logic                arr_we;
  logic [ADDR_W-1:0]   arr_waddr;
  logic [BE_W-1:0]     arr_wbe;
  logic [DATA_W-1:0]   arr_wdata;
  logic                arr_re;

  assign ready    = (state == IDLE);
  assign in_range = (int'(addr) < DEPTH);
  // WAIT is always entered once, even with WAIT_CYC=0, so the access edge is E(WAIT_CYC+1).
  assign access   = (state == WAIT) && (wait_cnt == '0);

  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = req_addr;
    arr_wbe   = req_be;
    arr_wdata = req_wdata;
    arr_re    = 1'b0;
    if (state == INIT) begin
      arr_we    = 1'b1;
      arr_waddr = clear_cnt;
      arr_wbe   = '1;
      arr_wdata = '0;
    end else if (access && !rst) begin
      arr_we = (op == OP_WR);
      arr_re = (op == OP_RD);
    end
  end

  param_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wbe   (arr_wbe),
    .wdata (arr_wdata),
    .re    (arr_re),
    .raddr (req_addr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      clear_cnt <= '0;
      wait_cnt  <= '0;
      rvalid    <= 1'b0;
      err       <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      case (state)
        INIT: begin
          if (clear_cnt == ADDR_W'(DEPTH-1)) state <= IDLE;
          else                               clear_cnt <= clear_cnt + 1'b1;
        end
        IDLE: begin
          if (en) begin
            req_addr  <= addr;
            req_wdata <= wdata;
            req_be    <= be;
            op        <= decode_op(w_en, r_en, in_range);
            wait_cnt  <= WAIT_W'(WAIT_CYC);
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            state  <= RESP;
            rvalid <= (op == OP_RD);
            err    <= (op == OP_ERR);
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= INIT;
      endcase
    end
  end

endmodule
